rf_readout_sequencer: RTL

Parametrised digital readout controller for the analog RF readout front-end. Sequences one or more measurement frames:
- resets the analog front-end (AFE);
- opens an integration window;
- counts rising edges of per-channel comparator outputs;
- drains the per-channel counts through a valid/ready port.

It sits between the analog comparator pins and the digital output/serialiser logic of the tile top. It generalises the single-channel readout to NCH channels, a programmable window, saturation flags and continuous mode.

---
 rtl/rf_readout_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rf_readout_sequencer.sv
// Multi-channel RF readout sequencer: AFE reset, integration window,
// per-channel comparator edge counting and valid/ready drain of counts.
module rf_readout_sequencer #(
  parameter  int NCH        = 4,
  parameter  int CNT_W      = 8,
  parameter  int WIN_W      = 12,
  parameter  int RST_CYCLES = 4,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cont_mode,
  input  logic [WIN_W-1:0] window_len,
  input  logic [NCH-1:0]   comp_in,
  output logic             afe_rst,
  output logic             afe_en,
  output logic             busy,
  output logic [CNT_W-1:0] data_out,
  output logic [CHW-1:0]   data_chan,
  output logic             data_sat,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = (WIN_W > RW) ? WIN_W : RW;

  typedef enum logic [1:0] {
    IDLE,
    ARST,
    INTEG,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   s3;
  logic [NCH-1:0]   edg;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   sat;
  logic [WIN_W-1:0] win_lat;
  logic [TW-1:0]    tmr;
  logic [CHW-1:0]   k;
  logic             xfer;
  logic             last;
  logic             tmr_zero;
  logic             arst_entry;

  assign edg        = s2 & ~s3;
  assign xfer       = ena & data_valid & data_ready;
  assign last       = (k == CHW'(NCH - 1));
  assign tmr_zero   = (tmr == '0);
  assign arst_entry = (state_nxt == ARST) && (state != ARST);

  // Three-flop comparator synchroniser; runs regardless of ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= comp_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state; ena=0 freezes the sequence
  always_comb begin
    state_nxt = state;
    if (ena) begin
      unique case (state)
        IDLE:    if (start) state_nxt = ARST;
        ARST:    if (tmr_zero) state_nxt = INTEG;
        INTEG:   if (tmr_zero) state_nxt = DRAIN;
        DRAIN:   if (xfer && last)
                   state_nxt = cont_mode ? ARST : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window latch and shared reset/integration down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_lat <= '0;
      tmr     <= '0;
    end else if (ena) begin
      if (state == IDLE && start)
        win_lat <= (window_len == '0) ? WIN_W'(1) : window_len;
      if (arst_entry)
        tmr <= TW'(RST_CYCLES - 1);
      else if (state == ARST && tmr_zero)
        tmr <= TW'(win_lat) - TW'(1);
      else if (!tmr_zero)
        tmr <= tmr - TW'(1);
    end
  end

  // Per-channel saturating edge counters, cleared on each ARST entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      sat <= '0;
    end else if (ena) begin
      if (arst_entry) begin
        for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        sat <= '0;
      end else if (state == INTEG) begin
        for (int i = 0; i < NCH; i++) begin
          if (edg[i]) begin
            if (&cnt[i]) sat[i] <= 1'b1;
            else         cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Drain channel pointer and valid flag; k advances on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      data_valid <= 1'b0;
    end else if (ena) begin
      data_valid <= (state_nxt == DRAIN);
      if (xfer) k <= last ? '0 : k + CHW'(1);
    end
  end

  // Registered AFE controls and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afe_rst <= 1'b0;
      afe_en  <= 1'b0;
      busy    <= 1'b0;
    end else if (ena) begin
      afe_rst <= (state_nxt == ARST);
      afe_en  <= (state_nxt == INTEG);
      busy    <= (state_nxt != IDLE);
    end
  end

  assign data_out  = data_valid ? cnt[k] : '0;
  assign data_chan = data_valid ? k : '0;
  assign data_sat  = data_valid & sat[k];

endmodule
